// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Fetch buffer entries carry the PC alongside the instruction word.
package instr_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction memory read port, execute redirect and decode handshake.
// The master modport is the fetch unit's view; slave is the surrounding core/memory.
interface instr_fetch_unit_if
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  imem_rd_en;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [XLEN-1:0]       imem_rdata;
    logic                  redirect_valid;
    logic [XLEN-1:0]       redirect_pc;
    logic                  if_valid;
    logic                  if_ready;
    logic [XLEN-1:0]       if_pc;
    logic [XLEN-1:0]       if_instr;

    modport master (
        output imem_rd_en, imem_addr, if_valid, if_pc, if_instr,
        input  imem_rdata, redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  imem_rd_en, imem_addr, if_valid, if_pc, if_instr,
        output imem_rdata, redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries with registered head and a flush port.
// The caller guarantees push is only raised when space exists (or a pop frees it).
module instr_fetch_unit_fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign do_pop = pop && !empty;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)   wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(DEPTH));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: keeps the fetch PC, issues credit-limited imem reads and
// buffers responses for decode; execute redirects flush the stage.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_VECTOR,
    parameter int unsigned     ADDR_WIDTH = 10,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input logic                clk,
    input logic                reset,
    instr_fetch_unit_if.master bus
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, req_pc_q;
    logic            inflight_q;
    logic            rd_en, pop, push, credit;
    logic [CntW:0]   occupancy;
    logic [CntW-1:0] fifo_count;
    logic            fifo_empty, fifo_full;
    fetch_entry_t    fifo_head, push_entry;

    assign pop = !fifo_empty && bus.if_ready;

    // A pop this cycle frees a slot before the outstanding response can land.
    always_comb begin
        occupancy = {1'b0, fifo_count} - {{CntW{1'b0}}, pop} + {{CntW{1'b0}}, inflight_q};
        credit    = occupancy < (CntW + 1)'(FIFO_DEPTH);
        rd_en     = !reset && !bus.redirect_valid && credit;
    end

    // A response arriving during a redirect belongs to the old path and is dropped.
    assign push       = inflight_q && !bus.redirect_valid && (!fifo_full || pop);
    assign push_entry = '{pc: req_pc_q, instr: bus.imem_rdata};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = align_pc(bus.redirect_pc);
        end else if (rd_en) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= rd_en;
            if (rd_en) req_pc_q <= fetch_pc_q;
        end
    end

    instr_fetch_unit_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign bus.imem_rd_en = rd_en;
    assign bus.imem_addr  = fetch_pc_q[ADDR_WIDTH+1:2];
    assign bus.if_valid   = !fifo_empty;
    assign bus.if_pc      = fifo_empty ? '0 : fifo_head.pc;
    assign bus.if_instr   = fifo_empty ? '0 : fifo_head.instr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: table-driven cycle vectors plus directed redirect/reset
// sequences against a synchronous ROM model.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    instr_fetch_unit_if #(.ADDR_WIDTH(10)) bus ();

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .ADDR_WIDTH (10),
        .FIFO_DEPTH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        logic [9:0] idx;
        idx = pc[11:2];
        case (idx)
            10'd0:   return 32'h0000_0013;
            10'd1:   return 32'h0010_0093;
            10'd2:   return 32'h0020_0113;
            10'd3:   return 32'h0030_8193;
            default: return 32'hC000_0000 | {22'b0, idx};
        endcase
    endfunction

    // Synchronous ROM: data valid the cycle after the request.
    always @(posedge clk) begin
        if (bus.imem_rd_en) bus.imem_rdata <= rom_word({20'b0, bus.imem_addr, 2'b00});
    end

    typedef struct {
        logic        rst;
        logic        ready;
        logic        exp_rd;
        logic [9:0]  exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic ready, input logic rd,
                                input logic [9:0] addr, input logic valid,
                                input logic [31:0] pc, input logic [31:0] instr);
        vec_t v;
        v.rst = rst; v.ready = ready; v.exp_rd = rd; v.exp_addr = addr;
        v.exp_valid = valid; v.exp_pc = pc; v.exp_instr = instr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Expects n consecutive transfers starting at first_pc; ready held high.
    task automatic expect_stream(input string name, input logic [31:0] first_pc, input int n);
        logic [31:0] exp_pc;
        int          got;
        int          cyc;
        exp_pc = first_pc;
        got = 0;
        cyc = 0;
        bus.if_ready = 1'b1;
        while (got < n && cyc < 32) begin
            @(negedge clk);
            cyc++;
            if (bus.if_valid) begin
                check($sformatf("%s_pc%0d", name, got), bus.if_pc, exp_pc);
                check($sformatf("%s_instr%0d", name, got), bus.if_instr, rom_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                got++;
            end
        end
        if (got < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d transfers, expected %0d", name, got, n);
        end
    endtask

    initial begin
        bus.if_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;

        // Straight-line fetch with ready high.
        vecs.push_back(mk(1, 1, 0, 10'd0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(1, 1, 0, 10'd0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 10'd0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 10'd1, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 10'd2, 1, 32'h0, 32'h0000_0013));
        vecs.push_back(mk(0, 1, 1, 10'd3, 1, 32'h4, 32'h0010_0093));
        vecs.push_back(mk(0, 1, 1, 10'd4, 1, 32'h8, 32'h0020_0113));
        vecs.push_back(mk(0, 1, 1, 10'd5, 1, 32'hC, 32'h0030_8193));
        // Backpressure from the first valid for 5 cycles.
        vecs.push_back(mk(1, 0, 0, 10'd0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 10'd0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 10'd0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 10'd1, 0, 32'h0, 32'h0));
        for (int k = 0; k < 5; k++) vecs.push_back(mk(0, 0, 0, 10'd2, 1, 32'h0, 32'h0000_0013));
        vecs.push_back(mk(0, 1, 1, 10'd2, 1, 32'h0, 32'h0000_0013));
        vecs.push_back(mk(0, 1, 1, 10'd3, 1, 32'h4, 32'h0010_0093));
        vecs.push_back(mk(0, 1, 1, 10'd4, 1, 32'h8, 32'h0020_0113));
        vecs.push_back(mk(0, 1, 1, 10'd5, 1, 32'hC, 32'h0030_8193));

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            bus.if_ready = vecs[i].ready;
            @(negedge clk);
            check($sformatf("vec%0d_rd_en", i), 32'(bus.imem_rd_en), 32'(vecs[i].exp_rd));
            check($sformatf("vec%0d_addr", i), 32'(bus.imem_addr), 32'(vecs[i].exp_addr));
            check($sformatf("vec%0d_valid", i), 32'(bus.if_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid || vecs[i].rst) begin
                check($sformatf("vec%0d_pc", i), bus.if_pc, vecs[i].exp_pc);
                check($sformatf("vec%0d_instr", i), bus.if_instr, vecs[i].exp_instr);
            end
            @(posedge clk);
            #1;
        end

        // Redirect to an unaligned target while pc=4 is in flight.
        do_reset();
        bus.if_ready = 1'b1;
        next_cycle();
        next_cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0042;
        @(negedge clk);
        check("redir_xfer_pc", bus.if_pc, 32'h0);
        check("redir_no_req", 32'(bus.imem_rd_en), 32'd0);
        next_cycle();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_flushed_valid", 32'(bus.if_valid), 32'd0);
        check("redir_new_req", 32'(bus.imem_rd_en), 32'd1);
        check("redir_new_addr", 32'(bus.imem_addr), 32'h10);
        expect_stream("redir", 32'h0000_0040, 2);

        // Redirect in the same cycle decode accepts pc=8.
        do_reset();
        bus.if_ready = 1'b1;
        repeat (4) next_cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0100;
        @(negedge clk);
        check("xfer_redir_valid", 32'(bus.if_valid), 32'd1);
        check("xfer_redir_pc", bus.if_pc, 32'h8);
        next_cycle();
        bus.redirect_valid = 1'b0;
        expect_stream("xfer_redir", 32'h0000_0100, 2);

        // PC wrap at the top of the address space.
        do_reset();
        bus.if_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        check("wrap_no_req", 32'(bus.imem_rd_en), 32'd0);
        next_cycle();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("wrap_addr_top", 32'(bus.imem_addr), 32'h3FF);
        next_cycle();
        @(negedge clk);
        check("wrap_rd_en", 32'(bus.imem_rd_en), 32'd1);
        check("wrap_addr_zero", 32'(bus.imem_addr), 32'h0);
        expect_stream("wrap", 32'hFFFF_FFFC, 3);

        // One-cycle reset with the FIFO full of words from another path.
        do_reset();
        bus.if_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        next_cycle();
        bus.redirect_valid = 1'b0;
        repeat (4) next_cycle();
        @(negedge clk);
        check("full_valid", 32'(bus.if_valid), 32'd1);
        check("full_pc", bus.if_pc, 32'h200);
        check("full_no_req", 32'(bus.imem_rd_en), 32'd0);
        next_cycle();
        reset = 1'b1;
        #1;
        check("rst_valid", 32'(bus.if_valid), 32'd0);
        check("rst_pc", bus.if_pc, 32'h0);
        check("rst_rd_en", 32'(bus.imem_rd_en), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        bus.if_ready = 1'b1;
        @(negedge clk);
        check("post_rst_c0_valid", 32'(bus.if_valid), 32'd0);
        check("post_rst_c0_addr", 32'(bus.imem_addr), 32'h0);
        next_cycle();
        @(negedge clk);
        check("post_rst_c1_valid", 32'(bus.if_valid), 32'd0);
        next_cycle();
        expect_stream("post_rst", 32'h0000_0000, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
